// File: rtl/ibex_instr_bus_responder.sv
// Instruction-fetch bus responder: grants req/gnt fetches, reads a 1-cycle SRAM,
// and returns in-order rvalid responses after a fixed latency through a fall-through FIFO.
module ibex_instr_bus_responder #(
    parameter logic [31:0] MemBase        = 32'h0000_0000,
    parameter int unsigned MemSizeWords   = 1024,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    localparam int unsigned AW            = $clog2(MemSizeWords)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          instr_req_i,
    output logic          instr_gnt_o,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    input  logic          gnt_stall_i,
    input  logic          resp_stall_i,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [31:0]   mem_rdata_i,
    output logic          busy_o
);

    localparam int unsigned PW      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [2:0]  MaxOut  = 3'(MaxOutstanding);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MaxOutstanding - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [2:0]             cnt_q;
    logic [31:0]            offset;
    logic [31:0]            word_idx;
    logic                   in_range;
    logic                   gnt;
    logic                   rvalid;

    logic [RespLatency-1:0] vld_p;
    logic [RespLatency-1:0] err_p;
    logic [31:0]            tail_data;
    logic                   push;
    logic                   push_err;
    logic [31:0]            push_data;

    logic [31:0]            fifo_data [MaxOutstanding];
    logic [MaxOutstanding-1:0] fifo_err;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [2:0]             fcount;
    logic                   empty;
    logic                   wr_en;
    logic                   rd_en;
    logic [31:0]            head_data;
    logic                   head_err;

    // Address decode: unsigned wrap makes addresses below MemBase out of range.
    assign offset   = instr_addr_i - MemBase;
    assign word_idx = offset >> 2;
    assign in_range = word_idx < MemSizeWords;

    // A pop frees a slot in the same cycle, so a full responder can still grant.
    assign gnt = rst_ni & instr_req_i & ~gnt_stall_i & ((cnt_q < MaxOut) | rvalid);

    assign mem_req_o  = gnt & in_range;
    assign mem_addr_o = mem_req_o ? word_idx[AW-1:0] : '0;

    // Stage p0: per-grant metadata, shifted until the entry is complete
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p <= '0;
            err_p <= '0;
        end else begin
            vld_p[0] <= gnt;
            err_p[0] <= gnt & ~in_range;
            for (int k = 1; k < RespLatency; k++) begin
                vld_p[k] <= vld_p[k-1];
                err_p[k] <= err_p[k-1];
            end
        end
    end

    // Stage p1..: SRAM data captured the cycle after the strobe
    if (RespLatency == 1) begin : g_data_comb
        assign tail_data = mem_rdata_i;
    end else begin : g_data_reg
        logic [31:0] data_p [1:RespLatency-1];
        always_ff @(posedge clk_i) begin
            data_p[1] <= mem_rdata_i;
            for (int k = 2; k < RespLatency; k++) begin
                data_p[k] <= data_p[k-1];
            end
        end
        assign tail_data = data_p[RespLatency-1];
    end

    assign push      = vld_p[RespLatency-1];
    assign push_err  = err_p[RespLatency-1];
    assign push_data = push_err ? 32'h0 : tail_data;

    // Response FIFO: an entry arriving at an empty FIFO falls straight through.
    assign empty     = (fcount == 3'd0);
    assign rvalid    = (~empty | push) & ~resp_stall_i;
    assign head_data = empty ? push_data : fifo_data[rd_ptr];
    assign head_err  = empty ? push_err : fifo_err[rd_ptr];
    assign wr_en     = push & ~(empty & rvalid);
    assign rd_en     = rvalid & ~empty;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_err[wr_ptr]  <= push_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            fcount <= fcount + {2'b00, wr_en} - {2'b00, rd_en};
            cnt_q  <= cnt_q + {2'b00, gnt} - {2'b00, rvalid};
        end
    end

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = rvalid;
    assign instr_rdata_o  = rvalid ? head_data : 32'h0;
    assign instr_err_o    = rvalid & head_err;
    assign busy_o         = (cnt_q != 3'd0);

    a_params: assert property (@(posedge clk_i)
        RespLatency >= 1 && RespLatency <= 4 &&
        MaxOutstanding >= 1 && MaxOutstanding <= 4 &&
        MemSizeWords >= 2 && (MemSizeWords & (MemSizeWords - 1)) == 0 &&
        MemBase[1:0] == 2'b00);

    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (instr_req_i && !instr_gnt_o) |=> (!instr_req_i || $stable(instr_addr_i)));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && fcount == MaxOut && !rvalid));

endmodule
